// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl
//   Frame controller for one PIXEL_SENSOR pixel, or for a column of pixels
//   sharing one DATA bus. Each frame runs erase, exposure, ramp-ADC
//   conversion and read-out. The sampled pixel code is then handed
//   downstream on a valid/ready pair.
//
// Ports
//   clk, reset          system clock; asynchronous active-high reset
//   start, cfg_expose   frame request (accepted only when idle) and the
//                       number of VBN1 integration pulses for that frame
//   busy                accepted start .. code accepted downstream
//   pix_erase/expose    pixel ERASE / EXPOSE
//   pix_vbn1, pix_ramp  integration clock / conversion clock
//   pix_read            pixel READ
//   pix_data_o/_oe      ADC step counter toward the bus, plus its enable
//                       (the tristate itself lives at the top level)
//   pix_data_i          bus value, sampled at the end of READ
//   code, code_valid,   converted code toward the image data path
//   code_ready
//
// Build option
//   PIXEL_GRAY_COUNT_EN: the bus carries the Gray-coded step, and the
//   sampled code is converted back to binary. Without it, the bus carries
//   plain binary.
//
// All outputs are flops. Their next values are decoded from the next
// state and the next count, so each output changes on the same edge as
// the state.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   S_IDLE    | waiting for start
//   S_ERASE   | pix_erase high for ERASE_CYCLES cycles
//   S_EXPOSE  | pix_expose high for 2*N cycles, vbn1 toggling
//   S_CONVERT | counter driven on bus, 2 cycles per step, ramp toggling
//   S_TURN    | one idle cycle for bus turnaround
//   S_READ    | pix_read high for 2 cycles, sample at end
//   S_OUT     | code_valid high until code_ready

module pixel_readout_ctrl #(
   parameter int DW           = 8,
   parameter int ERASE_CYCLES = 4,
   parameter int EXP_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [EXP_W-1:0] cfg_expose,
   output logic             busy,
   output logic             pix_erase,
   output logic             pix_expose,
   output logic             pix_vbn1,
   output logic             pix_ramp,
   output logic             pix_read,
   output logic [DW-1:0]    pix_data_o,
   output logic             pix_data_oe,
   input  logic [DW-1:0]    pix_data_i,
   output logic [DW-1:0]    code,
   output logic             code_valid,
   input  logic             code_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_EXPOSE,
      S_CONVERT,
      S_TURN,
      S_READ,
      S_OUT
   } state_t;

   // One shared down-counter must hold 2*N-1, 2*2^DW-1 and ERASE_CYCLES-1.
   localparam int CW_A = (EXP_W > DW) ? EXP_W + 1 : DW + 1;
   localparam int CW_E = $clog2(ERASE_CYCLES + 1);
   localparam int CW   = (CW_A > CW_E) ? CW_A : CW_E;

   localparam logic [CW-1:0] ERASE_LAST = CW'(ERASE_CYCLES - 1);
   localparam logic [CW-1:0] CONV_LAST  = CW'((2 << DW) - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

`ifdef PIXEL_GRAY_COUNT_EN
   function automatic logic [DW-1:0] step_to_bus(input logic [DW-1:0] s);
      return s ^ (s >> 1);
   endfunction

   function automatic logic [DW-1:0] bus_to_code(input logic [DW-1:0] g);
      logic [DW-1:0] b;
      b = g;
      for (int i = DW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction
`else
   function automatic logic [DW-1:0] step_to_bus(input logic [DW-1:0] s);
      return s;
   endfunction

   function automatic logic [DW-1:0] bus_to_code(input logic [DW-1:0] g);
      return g;
   endfunction
`endif

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic [DW-1:0]      code_q, code_d;

   logic               busy_q, busy_d;
   logic               erase_q, erase_d;
   logic               expose_q, expose_d;
   logic               vbn1_q, vbn1_d;
   logic               ramp_q, ramp_d;
   logic               read_q, read_d;
   logic               oe_q, oe_d;
   logic [DW-1:0]      data_q, data_d;
   logic               valid_q, valid_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      code_d  = code_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ERASE;
               cnt_d   = ERASE_LAST;
               exp_d   = cfg_expose;
            end
         end

         S_ERASE: begin
            if (cnt_q == '0) begin
               if (exp_q == '0) begin
                  state_d = S_CONVERT;
                  cnt_d   = CONV_LAST;
               end else begin
                  state_d = S_EXPOSE;
                  cnt_d   = CW'({exp_q, 1'b0}) - CNT_ONE;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         S_EXPOSE: begin
            if (cnt_q == '0) begin
               state_d = S_CONVERT;
               cnt_d   = CONV_LAST;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         S_CONVERT: begin
            if (cnt_q == '0) begin
               state_d = S_TURN;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         S_TURN: begin
            state_d = S_READ;
            cnt_d   = CNT_ONE;
         end

         S_READ: begin
            if (cnt_q == '0) begin
               state_d = S_OUT;
               code_d  = bus_to_code(pix_data_i);
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         S_OUT: begin
            if (code_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The counts are odd on the first cycle of each pair: the 1st, 3rd, ...
   // cycle in EXPOSE, and the first cycle of each step in CONVERT. So bit 0
   // of the count gives both vbn1 and ramp. The step number is the
   // complement of the upper count bits, so the bus value only moves when
   // ramp rises.
   always_comb begin
      busy_d   = (state_d != S_IDLE);
      erase_d  = (state_d == S_ERASE);
      expose_d = (state_d == S_EXPOSE);
      vbn1_d   = (state_d == S_EXPOSE) && cnt_d[0];
      oe_d     = (state_d == S_CONVERT);
      ramp_d   = (state_d == S_CONVERT) && cnt_d[0];
      data_d   = '0;
      if (state_d == S_CONVERT) begin
         data_d = step_to_bus(~cnt_d[DW:1]);
      end
      read_d   = (state_d == S_READ);
      valid_d  = (state_d == S_OUT);
   end

   // The async clear drops pix_data_oe at once, so an abort never leaves
   // the bus driven.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         exp_q    <= '0;
         code_q   <= '0;
         busy_q   <= 1'b0;
         erase_q  <= 1'b0;
         expose_q <= 1'b0;
         vbn1_q   <= 1'b0;
         ramp_q   <= 1'b0;
         read_q   <= 1'b0;
         oe_q     <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         exp_q    <= exp_d;
         code_q   <= code_d;
         busy_q   <= busy_d;
         erase_q  <= erase_d;
         expose_q <= expose_d;
         vbn1_q   <= vbn1_d;
         ramp_q   <= ramp_d;
         read_q   <= read_d;
         oe_q     <= oe_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   assign busy        = busy_q;
   assign pix_erase   = erase_q;
   assign pix_expose  = expose_q;
   assign pix_vbn1    = vbn1_q;
   assign pix_ramp    = ramp_q;
   assign pix_read    = read_q;
   assign pix_data_oe = oe_q;
   assign pix_data_o  = data_q;
   assign code        = code_q;
   assign code_valid  = valid_q;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Bench for pixel_readout_ctrl. The reference model records only when a
// frame was accepted and its N. Each output is then derived from the
// cycle's offset into the frame timeline.
module tb_pixel_readout_ctrl;

   localparam int DW    = 8;
   localparam int E     = 4;
   localparam int EXP_W = 16;
   localparam int CONV  = 1 << (DW + 1);

`ifdef PIXEL_GRAY_COUNT_EN
   localparam logic [DW-1:0] CODE_A5 = 8'hC6;
   localparam logic [DW-1:0] STEP2   = 8'h03;
   localparam logic [DW-1:0] STEP3   = 8'h02;
`else
   localparam logic [DW-1:0] CODE_A5 = 8'hA5;
   localparam logic [DW-1:0] STEP2   = 8'h02;
   localparam logic [DW-1:0] STEP3   = 8'h03;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [EXP_W-1:0] cfg_expose;
   logic             busy, pix_erase, pix_expose, pix_vbn1, pix_ramp, pix_read;
   logic [DW-1:0]    pix_data_o;
   logic             pix_data_oe;
   logic [DW-1:0]    pix_data_i;
   logic [DW-1:0]    code;
   logic             code_valid;
   logic             code_ready;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   pixel_readout_ctrl #(.DW(DW), .ERASE_CYCLES(E), .EXP_W(EXP_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .cfg_expose (cfg_expose),
      .busy       (busy),
      .pix_erase  (pix_erase),
      .pix_expose (pix_expose),
      .pix_vbn1   (pix_vbn1),
      .pix_ramp   (pix_ramp),
      .pix_read   (pix_read),
      .pix_data_o (pix_data_o),
      .pix_data_oe(pix_data_oe),
      .pix_data_i (pix_data_i),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready)
   );

   // ---------------- reference model ----------------
   int            cyc    = 0;
   bit            m_busy = 1'b0;
   int            m_p    = 0;
   int            m_n    = 0;
   logic [DW-1:0] m_code = '0;

   function automatic logic [DW-1:0] enc(input int s);
`ifdef PIXEL_GRAY_COUNT_EN
      return DW'(s ^ (s >> 1));
`else
      return DW'(s);
`endif
   endfunction

   // The code is the step whose bus image matches the sampled value.
   function automatic logic [DW-1:0] dec(input logic [DW-1:0] v);
      for (int s = 0; s < (1 << DW); s++) begin
         if (enc(s) == v) return DW'(s);
      end
      return '0;
   endfunction

   // Cycle offset of the first OUT cycle; offset 0 is the start cycle.
   function automatic int lat(input int n);
      return 1 + E + 2 * n + CONV + 3;
   endfunction

   initial begin : model
      int k;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_busy = 1'b0;
            m_code = '0;
         end else if (m_busy) begin
            k = cyc - m_p + 1;
            if (k == lat(m_n) - 1) m_code = dec(pix_data_i);
            if (k >= lat(m_n) && code_ready) m_busy = 1'b0;
         end else if (start) begin
            m_busy = 1'b1;
            m_n    = int'(cfg_expose);
            m_p    = cyc + 1;
         end
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      int k, cs;
      logic e_busy, e_erase, e_expose, e_vbn1, e_ramp, e_read, e_oe, e_valid;
      logic [DW-1:0] e_data;
      forever begin
         @(negedge clk);
         e_busy = 0; e_erase = 0; e_expose = 0; e_vbn1 = 0; e_ramp = 0;
         e_read = 0; e_oe = 0; e_valid = 0; e_data = '0;
         if (m_busy) begin
            k      = cyc - m_p + 1;
            cs     = E + 2 * m_n + 1;
            e_busy = 1;
            if (k <= E) e_erase = 1;
            else if (k < cs) begin
               e_expose = 1;
               e_vbn1   = ((k - E - 1) % 2 == 0);
            end else if (k < cs + CONV) begin
               e_oe   = 1;
               e_ramp = ((k - cs) % 2 == 0);
               e_data = enc((k - cs) / 2);
            end else if (k == cs + CONV) begin
               e_oe = 0;
            end else if (k <= cs + CONV + 2) e_read = 1;
            else e_valid = 1;
         end
         chk("busy",       32'(busy),        32'(e_busy));
         chk("pix_erase",  32'(pix_erase),   32'(e_erase));
         chk("pix_expose", 32'(pix_expose),  32'(e_expose));
         chk("pix_vbn1",   32'(pix_vbn1),    32'(e_vbn1));
         chk("pix_ramp",   32'(pix_ramp),    32'(e_ramp));
         chk("pix_read",   32'(pix_read),    32'(e_read));
         chk("pix_data_oe",32'(pix_data_oe), 32'(e_oe));
         chk("pix_data_o", 32'(pix_data_o),  32'(e_data));
         chk("code_valid", 32'(code_valid),  32'(e_valid));
         chk("code",       32'(code),        32'(m_code));
         chk("oe_read_excl", 32'(pix_data_oe && pix_read), 32'd0);
         chk("pix_excl", 32'((pix_erase && pix_expose) || (pix_erase && pix_read) ||
                             (pix_expose && pix_read)), 32'd0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start(input int n);
      cfg_expose = EXP_W'(n);
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   int  lat_m, n_erase, n_expose, n_vrise, n_conv;
   bit  done, prev_vbn1, prev_ramp;
   logic [DW-1:0] prev_data, st2, st3;

   // Walk a frame from offset 1 until code_valid, and measure its timeline.
   task automatic measure_frame();
      lat_m = 1; n_erase = 0; n_expose = 0; n_vrise = 0; n_conv = 0;
      prev_vbn1 = 0; prev_ramp = 0; prev_data = '0; done = 0; st2 = '0; st3 = '0;
      for (int t = 0; t < 2000 && !done; t++) begin
         if (code_valid) done = 1;
         else begin
            n_erase  += int'(pix_erase);
            n_expose += int'(pix_expose);
            if (pix_vbn1 && !prev_vbn1) n_vrise++;
            if (pix_data_oe) begin
               if (n_conv == 4) st2 = pix_data_o;
               if (n_conv == 6) st3 = pix_data_o;
               if (pix_data_o != prev_data)
                  chk("data_on_ramp_rise", 32'(pix_ramp && !prev_ramp), 32'd1);
               n_conv++;
            end
            prev_vbn1 = pix_vbn1; prev_ramp = pix_ramp; prev_data = pix_data_o;
            tick();
            lat_m++;
         end
      end
      if (!done) chk("frame_timeout", 32'd0, 32'd1);
   endtask

   initial begin : main
      logic [DW-1:0] held;
      reset = 1'b1; start = 1'b0; cfg_expose = '0; code_ready = 1'b0; pix_data_i = '0;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_oe",   32'(pix_data_oe), 32'd0);
      chk("rst_code", 32'(code), 32'd0);
      reset = 1'b0;
      tick();

      // Frame A: N=3, downstream stalls, start pulsed during OUT.
      pix_data_i = 8'hA5;
      pulse_start(3);
      measure_frame();
      chk("A_latency",    32'(lat_m),    32'd526);
      chk("A_erase_cyc",  32'(n_erase),  32'd4);
      chk("A_expose_cyc", 32'(n_expose), 32'd6);
      chk("A_vbn1_rises", 32'(n_vrise),  32'd3);
      chk("A_conv_cyc",   32'(n_conv),   32'd512);
      chk("A_code",       32'(code),     32'(CODE_A5));
      held = code;
      for (int i = 0; i < 10; i++) begin
         pix_data_i = DW'($urandom);
         start = (i == 4);
         tick();
         chk("A_stall_valid", 32'(code_valid), 32'd1);
         chk("A_stall_busy",  32'(busy),       32'd1);
         chk("A_stall_code",  32'(code),       32'(held));
      end
      start = 1'b0;
      code_ready = 1'b1;
      start = 1'b1;          // same cycle OUT completes: must be ignored
      tick();
      start = 1'b0;
      chk("A_accept_busy",  32'(busy),       32'd0);
      chk("A_accept_valid", 32'(code_valid), 32'd0);
      tick();
      chk("A_start_ignored", 32'(busy), 32'd0);

      // Frame B: N=0, ready held high.
      pix_data_i = 8'hA5;
      pulse_start(0);
      measure_frame();
      chk("B_latency",    32'(lat_m),    32'd520);
      chk("B_expose_cyc", 32'(n_expose), 32'd0);
      chk("B_vbn1_rises", 32'(n_vrise),  32'd0);
      chk("B_step2",      32'(st2),      32'(STEP2));
      chk("B_step3",      32'(st3),      32'(STEP3));
      chk("B_code",       32'(code),     32'(CODE_A5));
      tick();
      chk("B_valid_1cyc", 32'(code_valid), 32'd0);
      chk("B_idle",       32'(busy),       32'd0);

      // Frame C: reset on the first cycle of conversion step 37.
      code_ready = 1'b0;
      pulse_start(1);
      done = 0;
      for (int t = 0; t < 400 && !done; t++) begin
         if (m_busy && (cyc - m_p + 1) == E + 2 + 1 + 74) done = 1;
         else tick();
      end
      if (!done) chk("C_wait_timeout", 32'd0, 32'd1);
      chk("C_pre_oe", 32'(pix_data_oe), 32'd1);
      reset = 1'b1;
      tick();
      chk("C_oe",    32'(pix_data_oe), 32'd0);
      chk("C_busy",  32'(busy),        32'd0);
      chk("C_outs",  32'({pix_erase, pix_expose, pix_vbn1, pix_ramp, pix_read,
                          code_valid}), 32'd0);
      chk("C_data",  32'(pix_data_o),  32'd0);
      chk("C_code",  32'(code),        32'd0);
      reset = 1'b0;
      tick();

      // Randomized traffic; the model checks every cycle.
      for (int t = 0; t < 8000; t++) begin
         start      = ($urandom_range(0, 29) == 0);
         cfg_expose = EXP_W'($urandom_range(0, 5));
         code_ready = 1'($urandom_range(0, 1));
         pix_data_i = DW'($urandom);
         reset      = ($urandom_range(0, 2999) == 0);
         tick();
      end
      reset = 1'b0;
      start = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
